// File: rtl/arbitro_bus_datos_pkg.sv
// Shared types and defaults for the dual-master data RAM arbiter.
// Holds the FSM state type, the bus width defaults and the latency counter width.
package arbitro_bus_datos_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned CNT_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } estado_e;

endpackage

// File: rtl/arbitro_bus_datos_if.sv
// Master-side handshakes and RAM-side strobes of the data bus arbiter.
// The "slave" modport is the arbiter; "master" is the core/loader/RAM side.
interface arbitro_bus_datos_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
);
  logic              i_req0;
  logic              i_req1;
  logic              i_we0;
  logic              i_we1;
  logic [ADDR_W-1:0] i_addr0;
  logic [ADDR_W-1:0] i_addr1;
  logic [DATA_W-1:0] i_wdata0;
  logic [DATA_W-1:0] i_wdata1;
  logic              o_gnt0;
  logic              o_gnt1;
  logic              o_ack0;
  logic              o_ack1;
  logic [DATA_W-1:0] o_rdata0;
  logic [DATA_W-1:0] o_rdata1;
  logic              o_mem_en;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              o_ocupado;

  modport slave (
    input  i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1,
           i_wdata0, i_wdata1, i_mem_rdata,
    output o_gnt0, o_gnt1, o_ack0, o_ack1, o_rdata0, o_rdata1,
           o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_ocupado
  );

  modport master (
    output i_req0, i_req1, i_we0, i_we1, i_addr0, i_addr1,
           i_wdata0, i_wdata1, i_mem_rdata,
    input  o_gnt0, o_gnt1, o_ack0, o_ack1, o_rdata0, o_rdata1,
           o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_ocupado
  );

endinterface

// File: rtl/arbitro_bus_datos_rr_selector_2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the master
// that did not win last time. Purely combinational, one-hot result.
module rr_selector_2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/arbitro_bus_datos.sv
// Shares one single-port data RAM between the CPU data bus (M0) and the loader (M1).
// One access in flight: IDLE -> ISSUE -> [WAIT] -> RESP, every output registered.
module arbitro_bus_datos
  import arbitro_bus_datos_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned PRIO_INICIAL = 0
) (
  input  logic                 Clk,
  input  logic                 Rst,
  arbitro_bus_datos_if.slave   bus
);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_lat_chk
    $error("arbitro_bus_datos: MEM_LAT must be in 1..4");
  end

  localparam logic [CNT_W-1:0] LAT_INI  = CNT_W'(MEM_LAT);
  localparam logic             LAST_INI = ~1'(PRIO_INICIAL);

  estado_e           estado_q,   estado_d;
  logic              last_gnt_q, last_gnt_d;
  logic              win_q,      win_d;
  logic              we_q,       we_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic              gnt0_q,     gnt0_d;
  logic              gnt1_q,     gnt1_d;
  logic              ack0_q,     ack0_d;
  logic              ack1_q,     ack1_d;
  logic              mem_en_q,   mem_en_d;
  logic              mem_we_q,   mem_we_d;
  logic              ocupado_q,  ocupado_d;
  logic [DATA_W-1:0] rdata0_q,   rdata0_d;
  logic [DATA_W-1:0] rdata1_q,   rdata1_d;
  logic [1:0]        sel_gnt;

  rr_selector_2 u_sel (
    .req      ({bus.i_req1, bus.i_req0}),
    .last_gnt (last_gnt_q),
    .gnt      (sel_gnt)
  );

  // Outputs are registered from the next state, so the strobe/ack/gnt seen in a
  // cycle always match the state the FSM occupies in that same cycle.
  always_comb begin
    estado_d   = estado_q;
    last_gnt_d = last_gnt_q;
    win_d      = win_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    gnt0_d     = gnt0_q;
    gnt1_d     = gnt1_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    ocupado_d  = ocupado_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;

    unique case (estado_q)
      ST_IDLE: begin
        if (|sel_gnt) begin
          win_d     = sel_gnt[1];
          we_d      = sel_gnt[1] ? bus.i_we1    : bus.i_we0;
          addr_d    = sel_gnt[1] ? bus.i_addr1  : bus.i_addr0;
          wdata_d   = sel_gnt[1] ? bus.i_wdata1 : bus.i_wdata0;
          gnt0_d    = sel_gnt[0];
          gnt1_d    = sel_gnt[1];
          mem_en_d  = 1'b1;
          mem_we_d  = sel_gnt[1] ? bus.i_we1 : bus.i_we0;
          ocupado_d = 1'b1;
          estado_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          ack0_d   = ~win_q;
          ack1_d   = win_q;
          estado_d = ST_RESP;
        end else begin
          cnt_d    = LAT_INI;
          estado_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          if (win_q) rdata1_d = bus.i_mem_rdata;
          else       rdata0_d = bus.i_mem_rdata;
          ack0_d   = ~win_q;
          ack1_d   = win_q;
          estado_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        last_gnt_d = win_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        ocupado_d  = 1'b0;
        estado_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      estado_q   <= ST_IDLE;
      last_gnt_q <= LAST_INI;
      win_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      ocupado_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      estado_q   <= estado_d;
      last_gnt_q <= last_gnt_d;
      win_q      <= win_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      ocupado_q  <= ocupado_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign bus.o_gnt0      = gnt0_q;
  assign bus.o_gnt1      = gnt1_q;
  assign bus.o_ack0      = ack0_q;
  assign bus.o_ack1      = ack1_q;
  assign bus.o_rdata0    = rdata0_q;
  assign bus.o_rdata1    = rdata1_q;
  assign bus.o_mem_en    = mem_en_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = addr_q;
  assign bus.o_mem_wdata = wdata_q;
  assign bus.o_ocupado   = ocupado_q;

endmodule
